// File: rtl/dig_spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between N_REQ requesters, with a
// chip-select gap between transactions and a watchdog that aborts hung transfers.
module dig_spi_arbiter #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned WR_W           = 16,
  parameter int unsigned RD_W           = 8,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      sel,
  input  logic [N_REQ*WR_W-1:0] wr_data,
  output logic [N_REQ-1:0]      ack,
  output logic                  err,
  output logic [RD_W-1:0]       rd_data,
  output logic                  m_req,
  output logic                  m_sel,
  output logic [WR_W-1:0]       m_wr_data,
  input  logic                  m_ack,
  input  logic [RD_W-1:0]       m_rd_data,
  output logic                  busy,
  output logic [2:0]            grant_id,
  output logic [7:0]            timeout_cnt
);

  localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e          state_q;
  logic [2:0]      ptr_q;
  logic [WdW-1:0]  wd_q;
  logic [GapW-1:0] gap_q;

  // Requester inputs widened to 8 entries so a 3-bit index always fits exactly.
  logic [7:0]      req_ext;
  logic [7:0]      sel_ext;
  logic [WR_W-1:0] wr_arr [8];
  logic            any_req;
  logic [2:0]      winner;
  logic [2:0]      next_ptr;
  logic [3:0]      cand;

  always_comb begin
    req_ext = 8'(req);
    sel_ext = 8'(sel);
    for (int unsigned i = 0; i < 8; i++) begin
      wr_arr[i] = '0;
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      wr_arr[i] = wr_data[i*WR_W +: WR_W];
    end

    // First requester at or after ptr_q, wrapping modulo N_REQ.
    any_req = 1'b0;
    winner  = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + 4'(k);
      if (cand >= 4'(N_REQ)) begin
        cand = cand - 4'(N_REQ);
      end
      if (!any_req && req_ext[cand[2:0]]) begin
        any_req = 1'b1;
        winner  = cand[2:0];
      end
    end
    next_ptr = (winner == 3'(N_REQ - 1)) ? 3'd0 : winner + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      wd_q        <= '0;
      gap_q       <= '0;
      ack         <= '0;
      err         <= 1'b0;
      rd_data     <= '0;
      m_req       <= 1'b0;
      m_sel       <= 1'b0;
      m_wr_data   <= '0;
      busy        <= 1'b0;
      grant_id    <= '0;
      timeout_cnt <= '0;
    end else begin
      ack <= '0;
      case (state_q)
        StIdle: begin
          if (any_req) begin
            m_req     <= 1'b1;
            m_sel     <= sel_ext[winner];
            m_wr_data <= wr_arr[winner];
            grant_id  <= winner;
            ptr_q     <= next_ptr;
            wd_q      <= '0;
            busy      <= 1'b1;
            state_q   <= StGrant;
          end
        end
        StGrant: begin
          // A completion on the watchdog's final cycle still counts as success.
          if (m_ack) begin
            m_req   <= 1'b0;
            ack     <= N_REQ'(1) << grant_id;
            err     <= 1'b0;
            rd_data <= m_rd_data;
            gap_q   <= '0;
            state_q <= StGap;
          end else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
            m_req   <= 1'b0;
            ack     <= N_REQ'(1) << grant_id;
            err     <= 1'b1;
            rd_data <= '1;
            if (timeout_cnt != 8'hFF) begin
              timeout_cnt <= timeout_cnt + 8'd1;
            end
            gap_q   <= '0;
            state_q <= StGap;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        StGap: begin
          if (gap_q == GapW'(GAP_CYCLES - 1)) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: begin
          m_req   <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dig_spi_arbiter.sv
// Directed bench for dig_spi_arbiter: a transaction-level model checked every cycle,
// plus literal expectations on the key events of each scenario.
module tb_dig_spi_arbiter;

  localparam int N   = 2;
  localparam int WW  = 16;
  localparam int RW  = 8;
  localparam int GAP = 8;
  localparam int TO  = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req;
  logic [N-1:0]    sel;
  logic [N*WW-1:0] wr_data;
  logic [N-1:0]    ack;
  logic            err;
  logic [RW-1:0]   rd_data;
  logic            m_req;
  logic            m_sel;
  logic [WW-1:0]   m_wr_data;
  logic            m_ack;
  logic [RW-1:0]   m_rd_data;
  logic            busy;
  logic [2:0]      grant_id;
  logic [7:0]      timeout_cnt;

  dig_spi_arbiter #(
    .N_REQ(N), .WR_W(WW), .RD_W(RW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .sel(sel), .wr_data(wr_data),
    .ack(ack), .err(err), .rd_data(rd_data), .m_req(m_req), .m_sel(m_sel),
    .m_wr_data(m_wr_data), .m_ack(m_ack), .m_rd_data(m_rd_data), .busy(busy),
    .grant_id(grant_id), .timeout_cnt(timeout_cnt)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: who owns the master, for how long, and how much gap is left.
  bit           mgranted;
  int           age;
  int           gap_left;
  int           last_w;
  int           c;
  logic [N-1:0] e_ack;
  logic         e_err, e_mreq, e_msel;
  logic [7:0]   e_rd, e_tcnt;
  logic [15:0]  e_mwd;
  int           e_gid;

  always @(posedge clk) begin
    e_ack = '0;
    if (!rst_n) begin
      mgranted = 0; age = 0; gap_left = 0; last_w = N - 1;
      e_err = 0; e_rd = 0; e_mreq = 0; e_msel = 0; e_mwd = 0; e_gid = 0; e_tcnt = 0;
    end else if (mgranted) begin
      age++;
      if (m_ack || age == TO) begin
        e_ack[e_gid] = 1'b1;
        e_err = !m_ack;
        e_rd = m_ack ? m_rd_data : 8'hFF;
        if (!m_ack && e_tcnt != 8'hFF) e_tcnt++;
        mgranted = 0;
        e_mreq = 0;
        gap_left = GAP;
      end
    end else if (gap_left > 0) begin
      gap_left--;
    end else begin
      for (int k = 1; k <= N; k++) begin
        c = (last_w + k) % N;
        if (req[c]) begin
          mgranted = 1; age = 0; last_w = c;
          e_mreq = 1; e_msel = sel[c]; e_mwd = wr_data[c*WW +: WW]; e_gid = c;
          break;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", ack, e_ack);
      check("err", err, e_err);
      check("rd_data", rd_data, e_rd);
      check("m_req", m_req, e_mreq);
      check("m_sel", m_sel, e_msel);
      check("m_wr_data", m_wr_data, e_mwd);
      check("busy", busy, (mgranted || gap_left > 0));
      check("grant_id", grant_id, 32'(e_gid));
      check("timeout_cnt", timeout_cnt, e_tcnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mreq();
    for (int i = 0; i < 100 && !m_req; i++) tick();
    check("m_req_rise", m_req, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) tick();
    check("back_to_idle", busy, 0);
  endtask

  task automatic ack_after(input int n, input logic [7:0] d);
    repeat (n) tick();
    m_ack = 1'b1;
    m_rd_data = d;
    tick();
    m_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    req = '0; sel = '0; wr_data = '0; m_ack = 1'b0; m_rd_data = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_m_req", m_req, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_cnt", timeout_cnt, 0);
    rst_n = 1'b1;

    // Contention: both held, grants alternate starting at requester 0.
    req = 2'b11; sel = 2'b10; wr_data = {16'hB222, 16'hA111};
    for (int i = 0; i < 4; i++) begin
      wait_mreq();
      check("rr_grant_id", grant_id, i % 2);
      check("rr_m_wr_data", m_wr_data, (i % 2) ? 16'hB222 : 16'hA111);
      check("rr_m_sel", m_sel, i % 2);
      ack_after(3, 8'(8'h10 + i));
      if (i == 3) req = '0;
      check("rr_ack", ack, (i % 2) ? 2 : 1);
    end
    wait_idle();

    // Single request, plus spurious acks during the gap and in idle.
    req = 2'b01; sel = 2'b01; wr_data = {16'h0000, 16'h8A05};
    tick();
    check("single_m_req_latency", m_req, 1);
    check("single_m_sel", m_sel, 1);
    check("single_m_wr_data", m_wr_data, 16'h8A05);
    ack_after(39, 8'h3C);
    req = '0;
    check("single_ack", ack, 2'b01);
    check("single_rd_data", rd_data, 8'h3C);
    check("single_err", err, 0);
    for (int i = 0; i < GAP; i++) begin
      m_ack = (i == 2);
      tick();
      check("gap_m_req_low", m_req, 0);
    end
    m_ack = 1'b0;
    wait_idle();
    m_ack = 1'b1; m_rd_data = 8'h77;
    tick();
    m_ack = 1'b0;
    check("idle_spurious_ack", ack, 0);
    check("idle_spurious_rd_data", rd_data, 8'h3C);

    // Requester inputs change mid-transaction; latched command must hold.
    req = 2'b01; sel = 2'b00; wr_data = {16'h0000, 16'h1234};
    wait_mreq();
    repeat (5) tick();
    wr_data = {16'h0000, 16'hFFFF}; sel = 2'b01;
    repeat (5) tick();
    check("hold_m_wr_data", m_wr_data, 16'h1234);
    check("hold_m_sel", m_sel, 0);
    ack_after(2, 8'h55);
    req = '0;
    wait_idle();

    // Timeout: master never acks; req dropped after the grant.
    req = 2'b01; wr_data = {16'h0000, 16'h0F0F};
    wait_mreq();
    req = '0;
    n = 0;
    do begin
      tick();
      n++;
    end while (m_req && n < 200);
    check("timeout_m_req_cycles", n, TO);
    check("timeout_ack", ack, 2'b01);
    check("timeout_err", err, 1);
    check("timeout_rd_data", rd_data, 8'hFF);
    check("timeout_cnt_1", timeout_cnt, 1);
    wait_idle();

    // m_ack on the very cycle the watchdog expires: success wins.
    req = 2'b01;
    wait_mreq();
    req = '0;
    repeat (TO - 1) tick();
    m_ack = 1'b1; m_rd_data = 8'h5A;
    tick();
    m_ack = 1'b0;
    check("coinc_ack", ack, 2'b01);
    check("coinc_err", err, 0);
    check("coinc_rd_data", rd_data, 8'h5A);
    check("coinc_timeout_cnt", timeout_cnt, 1);
    wait_idle();

    // Reset in cycle 10 of a grant; afterwards arbitration restarts at requester 0.
    req = 2'b01;
    wait_mreq();
    repeat (10) tick();
    rst_n = 1'b0; req = '0;
    tick();
    check("rst_mid_m_req", m_req, 0);
    check("rst_mid_ack", ack, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rd_data", rd_data, 0);
    check("rst_mid_timeout_cnt", timeout_cnt, 0);
    rst_n = 1'b1; req = 2'b11; wr_data = {16'hB222, 16'hA111};
    wait_mreq();
    check("rst_ptr_grant_id", grant_id, 0);
    ack_after(2, 8'h66);
    req = '0;
    check("rst_after_ack", ack, 2'b01);
    wait_idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
